wb_scoreboard: RTL and testbench
================================

Name: wb_scoreboard

Overview:
- Writeback-end tracker for long-latency results: divider (M), FPU (F), and the atomic/bitmanip multi-cycle paths.
- Decode side marks a destination register pending at issue; writeback side releases it when the result retires.
- Produces the decode stall for RAW/WAW hazards against in-flight multi-cycle ops, and caps outstanding ops.
- Sits beside the MEM/WB control register; consumes the same W-stage reg-write qualifier.

Parameters:
- MAX_OUT, 4, maximum simultaneously pending multi-cycle destinations (1..15)
- UNIT_W, 2, width of the functional-unit tag

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- issue_valid_i  in  1  decode issuing a multi-cycle op this cycle (already qualified by ~stall_o)
- issue_rd_i  in  5  destination register index
- issue_fp_i  in  1  destination is the FP file (1) or the integer file (0)
- issue_unit_i  in  UNIT_W  unit tag of the issuing op
- rs1_i, rs2_i, rs3_i  in  5 each  decode source indices
- rs1_fp_i, rs2_fp_i, rs3_fp_i  in  1 each  source register file selects
- rs_used_i  in  3  per-source use enables [2]=rs3 [1]=rs2 [0]=rs1
- rd_i, rd_fp_i, rd_used_i  in  5/1/1  decode destination, checked for WAW
- wb_valid_i  in  1  multi-cycle result retiring (reg_write_w qualified)
- wb_rd_i  in  5  retiring destination index
- wb_fp_i  in  1  retiring destination file select
- wb_unit_i  in  UNIT_W  unit tag of the retiring result
- stall_o  out  1  decode must hold
- out_cnt_o  out  $clog2(MAX_OUT+1)  number of pending entries
- busy_o  out  64  pending bitmap: [31:0] integer, [63:32] FP

Behaviour:
- State: 64 busy bits, 64 unit tags, outstanding counter. Index = {fp, rd}.
- Reset: all busy bits 0, tags 0, out_cnt_o=0, stall_o=0 (and err_o=0 when the feature is present).
- Integer x0 is never marked busy; issue to x0 is ignored and does not change the count. f0 is tracked normally.
- Issue (issue_valid_i=1): set busy[idx] and tag[idx]=issue_unit_i at the next clock edge; count +1.
- Writeback (wb_valid_i=1 and busy[idx]=1 and tag[idx]==wb_unit_i): clear busy[idx] at the next clock edge; count -1.
- A writeback with no matching busy entry or a mismatched tag changes no state.
- Same cycle, same index, issue and writeback: set wins; the entry stays busy with the new tag and the count is unchanged.
- Same cycle, different indices: both take effect; the count is unchanged.
- stall_o is combinational and asserts if any of the following holds:
  - an enabled source has busy=1 and is not being released by the current matching writeback (same-cycle bypass releases the hazard);
  - rd_used_i=1 and the destination is busy (WAW);
  - out_cnt_o==MAX_OUT and no release this cycle.
- stall_o never depends on issue_valid_i, so there is no combinational loop with decode.
- Count never exceeds MAX_OUT and never underflows. Issue while full is illegal; the bench asserts it never occurs.
- No flush input: in-flight multi-cycle ops always retire and release their entry.
- Reset asserted mid-operation clears all state immediately (asynchronous).

Optional Feature:
- Macro: WB_SCOREBOARD_ERR_EN.
- Defined:
  - adds output err_o (1 bit);
  - err_o is set sticky on wb_valid_i to a non-busy entry, tag mismatch, issue to a busy entry, or issue while full;
  - err_o is cleared only by reset.
- Undefined: no err_o port; illegal events are silently ignored as described above.

Test Plan:
- Reset then idle -> busy_o=0, out_cnt_o=0, stall_o=0.
- Issue rd=x5 unit=1; next cycle rs1=x5 used -> stall_o=1. wb x5 unit=1 in the same cycle as that decode -> stall_o=0 (bypass); following cycle busy_o[5]=0.
- Issue f3 (idx 35) unit=2, then wb f3 unit=1 -> no clear, busy_o[35] stays 1. With ERR_EN, err_o=1.
- Four issues to x1, x2, f1, f2 with MAX_OUT=4 -> out_cnt_o=4, stall_o=1 with no sources used. One wb of x2 -> stall_o=0 in that same cycle; out_cnt_o=3 next cycle.
- Issue to x0 -> busy_o=0, out_cnt_o=0. Issue x7 and wb of an older x7 (matching tag) in the same cycle -> busy_o[7]=1, tag=new unit.
- Assert rst_n_i mid-stream with 3 pending -> outputs zero asynchronously before the next edge.

Source files
------------

// File: rtl/wb_scoreboard.sv
// Writeback scoreboard for long-latency results. It tracks pending destinations and raises the decode stall.
// Define WB_SCOREBOARD_ERR_EN to add the sticky err_o illegal-event flag.
module wb_scoreboard #(
  parameter  int MAX_OUT = 4,
  parameter  int UNIT_W  = 2,
  localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              issue_valid_i,
  input  logic [4:0]        issue_rd_i,
  input  logic              issue_fp_i,
  input  logic [UNIT_W-1:0] issue_unit_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [4:0]        rs3_i,
  input  logic              rs1_fp_i,
  input  logic              rs2_fp_i,
  input  logic              rs3_fp_i,
  input  logic [2:0]        rs_used_i,
  input  logic [4:0]        rd_i,
  input  logic              rd_fp_i,
  input  logic              rd_used_i,
  input  logic              wb_valid_i,
  input  logic [4:0]        wb_rd_i,
  input  logic              wb_fp_i,
  input  logic [UNIT_W-1:0] wb_unit_i,
  output logic              stall_o,
  output logic [CNT_W-1:0]  out_cnt_o,
  output logic [63:0]       busy_o
`ifdef WB_SCOREBOARD_ERR_EN
  ,
  output logic              err_o
`endif
);

  logic [63:0]       r_busy;
  logic [UNIT_W-1:0] r_tag [64];
  logic [CNT_W-1:0]  r_cnt;

  logic [5:0] w_issueIdx;
  logic [5:0] w_wbIdx;
  logic [5:0] w_rdIdx;
  logic [5:0] w_srcIdx [3];
  logic       w_issueEn;
  logic       w_wbRel;
  logic       w_full;
  logic       w_rawHaz;
  logic       w_wawHaz;

  assign w_issueIdx  = {issue_fp_i, issue_rd_i};
  assign w_wbIdx     = {wb_fp_i, wb_rd_i};
  assign w_rdIdx     = {rd_fp_i, rd_i};
  assign w_srcIdx[0] = {rs1_fp_i, rs1_i};
  assign w_srcIdx[1] = {rs2_fp_i, rs2_i};
  assign w_srcIdx[2] = {rs3_fp_i, rs3_i};

  // Integer x0 is hardwired, so an issue to it never occupies an entry.
  assign w_issueEn = issue_valid_i & (issue_fp_i | (issue_rd_i != 5'd0));
  assign w_wbRel   = wb_valid_i & r_busy[w_wbIdx] & (r_tag[w_wbIdx] == wb_unit_i);
  assign w_full    = (r_cnt == CNT_W'(MAX_OUT));
  assign w_wawHaz  = rd_used_i & r_busy[w_rdIdx];

  // A source whose producer retires this cycle is bypassed and does not stall.
  always_comb begin
    w_rawHaz = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rs_used_i[i] && r_busy[w_srcIdx[i]] && !(w_wbRel && (w_srcIdx[i] == w_wbIdx)))
        w_rawHaz = 1'b1;
    end
  end

  assign stall_o   = w_rawHaz | w_wawHaz | (w_full & ~w_wbRel);
  assign busy_o    = r_busy;
  assign out_cnt_o = r_cnt;

  // The clear is applied before the set, so a same-index issue keeps the entry busy.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_busy <= '0;
    end else begin
      if (w_wbRel)   r_busy[w_wbIdx]    <= 1'b0;
      if (w_issueEn) r_busy[w_issueIdx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 64; i++) r_tag[i] <= '0;
    end else if (w_issueEn) begin
      r_tag[w_issueIdx] <= issue_unit_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else begin
      case ({w_issueEn, w_wbRel})
        2'b10:   if (!w_full) r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifdef WB_SCOREBOARD_ERR_EN
  logic r_err;
  logic w_errEvt;

  assign w_errEvt = (wb_valid_i & ~w_wbRel)
                  | (w_issueEn & r_busy[w_issueIdx] & ~(w_wbRel & (w_wbIdx == w_issueIdx)))
                  | (w_issueEn & w_full & ~w_wbRel);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      r_err <= 1'b0;
    else if (w_errEvt) r_err <= 1'b1;
  end

  assign err_o = r_err;
`endif

endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench for wb_scoreboard: directed scenarios plus randomized traffic against a behavioural model.
// err_o checks are compiled in when WB_SCOREBOARD_ERR_EN is defined.
module tb_wb_scoreboard;
  localparam int MAX_OUT = 4;
  localparam int UNIT_W  = 2;
  localparam int CNT_W   = $clog2(MAX_OUT + 1);

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              issue_valid_i;
  logic [4:0]        issue_rd_i;
  logic              issue_fp_i;
  logic [UNIT_W-1:0] issue_unit_i;
  logic [4:0]        rs1_i, rs2_i, rs3_i;
  logic              rs1_fp_i, rs2_fp_i, rs3_fp_i;
  logic [2:0]        rs_used_i;
  logic [4:0]        rd_i;
  logic              rd_fp_i, rd_used_i;
  logic              wb_valid_i;
  logic [4:0]        wb_rd_i;
  logic              wb_fp_i;
  logic [UNIT_W-1:0] wb_unit_i;
  logic              stall_o;
  logic [CNT_W-1:0]  out_cnt_o;
  logic [63:0]       busy_o;
`ifdef WB_SCOREBOARD_ERR_EN
  logic              err_o;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: one pending flag and unit tag per register, plus a plain count.
  bit mBusy [64];
  int mTag  [64];
  int mCnt;

  wb_scoreboard #(.MAX_OUT(MAX_OUT), .UNIT_W(UNIT_W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .issue_fp_i(issue_fp_i), .issue_unit_i(issue_unit_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rs3_i(rs3_i),
    .rs1_fp_i(rs1_fp_i), .rs2_fp_i(rs2_fp_i), .rs3_fp_i(rs3_fp_i), .rs_used_i(rs_used_i),
    .rd_i(rd_i), .rd_fp_i(rd_fp_i), .rd_used_i(rd_used_i),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_fp_i(wb_fp_i), .wb_unit_i(wb_unit_i),
    .stall_o(stall_o), .out_cnt_o(out_cnt_o), .busy_o(busy_o)
`ifdef WB_SCOREBOARD_ERR_EN
    , .err_o(err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "[TB] timeout");
  end

  // Decode only issues when not stalled, which also rules out issue-while-full.
  always @(negedge clk_i) begin
    if (rst_n_i) assert (!(issue_valid_i && stall_o))
      else $display("[TB] FAIL issue_legal: issue_valid_i=%0b while stall_o=%0b", issue_valid_i, stall_o);
  end

  function automatic int idxOf(logic fp, logic [4:0] r);
    return int'(fp) * 32 + int'(r);
  endfunction

  function automatic bit mRelease();
    int wi = idxOf(wb_fp_i, wb_rd_i);
    return wb_valid_i && mBusy[wi] && (mTag[wi] == int'(wb_unit_i));
  endfunction

  function automatic bit mStall();
    int sIdx [3];
    int wi = idxOf(wb_fp_i, wb_rd_i);
    bit rel = mRelease();
    sIdx[0] = idxOf(rs1_fp_i, rs1_i);
    sIdx[1] = idxOf(rs2_fp_i, rs2_i);
    sIdx[2] = idxOf(rs3_fp_i, rs3_i);
    for (int k = 0; k < 3; k++)
      if (rs_used_i[k] && mBusy[sIdx[k]] && !(rel && sIdx[k] == wi)) return 1'b1;
    if (rd_used_i && mBusy[idxOf(rd_fp_i, rd_i)]) return 1'b1;
    if (mCnt == MAX_OUT && !rel) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] mBusyVec();
    logic [63:0] v = '0;
    for (int i = 0; i < 64; i++) v[i] = mBusy[i];
    return v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 64; i++) begin
      mBusy[i] = 1'b0;
      mTag[i]  = 0;
    end
    mCnt = 0;
  endtask

  task automatic modelUpdate();
    bit rel = mRelease();
    bit iss = issue_valid_i && (issue_fp_i || issue_rd_i != 5'd0);
    if (rel) begin
      mBusy[idxOf(wb_fp_i, wb_rd_i)] = 1'b0;
      mCnt--;
    end
    if (iss) begin
      mBusy[idxOf(issue_fp_i, issue_rd_i)] = 1'b1;
      mTag[idxOf(issue_fp_i, issue_rd_i)]  = int'(issue_unit_i);
      mCnt++;
    end
  endtask

  task automatic setIdle();
    issue_valid_i = 0; issue_rd_i = 0; issue_fp_i = 0; issue_unit_i = 0;
    rs1_i = 0; rs2_i = 0; rs3_i = 0; rs1_fp_i = 0; rs2_fp_i = 0; rs3_fp_i = 0; rs_used_i = 0;
    rd_i = 0; rd_fp_i = 0; rd_used_i = 0;
    wb_valid_i = 0; wb_rd_i = 0; wb_fp_i = 0; wb_unit_i = 0;
  endtask

  task automatic applyStimulus(input bit doIss, input logic iFp, input logic [4:0] iRd, input logic [UNIT_W-1:0] iUnit,
                               input bit doWb, input logic wFp, input logic [4:0] wRd, input logic [UNIT_W-1:0] wUnit);
    issue_valid_i = doIss; issue_fp_i = iFp; issue_rd_i = iRd; issue_unit_i = iUnit;
    wb_valid_i = doWb; wb_fp_i = wFp; wb_rd_i = wRd; wb_unit_i = wUnit;
  endtask

  task automatic tick();
    modelUpdate();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    setIdle();
    rst_n_i = 0;
    modelReset();
    #3;
    checks++; if (busy_o !== 64'd0) begin errors++; $display("[TB] FAIL reset_busy: got %h expected 0", busy_o); end
    checks++; if (out_cnt_o !== '0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", out_cnt_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", stall_o); end
    @(negedge clk_i);
    rst_n_i = 1;
    tick();
    tick();
    checks++; if (busy_o !== 64'd0 || out_cnt_o !== '0) begin errors++; $display("[TB] FAIL idle_state: busy %h cnt %0d expected 0/0", busy_o, out_cnt_o); end
  endtask

  task automatic test_raw_bypass();
    setIdle();
    applyStimulus(1, 0, 5'd5, 2'd1, 0, 0, 0, 0);
    tick();
    setIdle();
    checks++; if (busy_o[5] !== 1'b1 || out_cnt_o !== 3'd1) begin errors++; $display("[TB] FAIL raw_issue: busy5 %b cnt %0d expected 1/1", busy_o[5], out_cnt_o); end
    rs1_i = 5'd5; rs1_fp_i = 0; rs_used_i = 3'b001;
    #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("[TB] FAIL raw_stall: got %b expected 1", stall_o); end
    applyStimulus(0, 0, 0, 0, 1, 0, 5'd5, 2'd1);
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL raw_bypass: got %b expected 0", stall_o); end
    tick();
    setIdle();
    checks++; if (busy_o[5] !== 1'b0 || out_cnt_o !== 3'd0) begin errors++; $display("[TB] FAIL raw_release: busy5 %b cnt %0d expected 0/0", busy_o[5], out_cnt_o); end
  endtask

  task automatic test_tag_mismatch();
    setIdle();
    applyStimulus(1, 1, 5'd3, 2'd2, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 1, 5'd3, 2'd1);
    tick();
    setIdle();
    checks++; if (busy_o[35] !== 1'b1 || out_cnt_o !== 3'd1) begin errors++; $display("[TB] FAIL tag_mismatch: busy35 %b cnt %0d expected 1/1", busy_o[35], out_cnt_o); end
`ifdef WB_SCOREBOARD_ERR_EN
    checks++; if (err_o !== 1'b1) begin errors++; $display("[TB] FAIL err_flag: got %b expected 1", err_o); end
`endif
    applyStimulus(0, 0, 0, 0, 1, 1, 5'd3, 2'd2);
    tick();
    setIdle();
    checks++; if (busy_o !== 64'd0 || out_cnt_o !== 3'd0) begin errors++; $display("[TB] FAIL tag_match_clear: busy %h cnt %0d expected 0/0", busy_o, out_cnt_o); end
  endtask

  task automatic test_full();
    setIdle();
    applyStimulus(1, 0, 5'd1, 2'd0, 0, 0, 0, 0); tick();
    applyStimulus(1, 0, 5'd2, 2'd1, 0, 0, 0, 0); tick();
    applyStimulus(1, 1, 5'd1, 2'd2, 0, 0, 0, 0); tick();
    applyStimulus(1, 1, 5'd2, 2'd3, 0, 0, 0, 0); tick();
    setIdle();
    #1;
    checks++; if (out_cnt_o !== 3'd4) begin errors++; $display("[TB] FAIL full_cnt: got %0d expected 4", out_cnt_o); end
    checks++; if (stall_o !== 1'b1) begin errors++; $display("[TB] FAIL full_stall: got %b expected 1", stall_o); end
    applyStimulus(0, 0, 0, 0, 1, 0, 5'd2, 2'd1);
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL full_release_stall: got %b expected 0", stall_o); end
    tick();
    setIdle();
    checks++; if (out_cnt_o !== 3'd3 || busy_o[2] !== 1'b0) begin errors++; $display("[TB] FAIL full_after_wb: cnt %0d busy2 %b expected 3/0", out_cnt_o, busy_o[2]); end
    applyStimulus(0, 0, 0, 0, 1, 0, 5'd1, 2'd0); tick();
    applyStimulus(0, 0, 0, 0, 1, 1, 5'd1, 2'd2); tick();
    applyStimulus(0, 0, 0, 0, 1, 1, 5'd2, 2'd3); tick();
    setIdle();
    checks++; if (out_cnt_o !== 3'd0 || busy_o !== 64'd0) begin errors++; $display("[TB] FAIL full_drain: cnt %0d busy %h expected 0/0", out_cnt_o, busy_o); end
  endtask

  task automatic test_x0_same_idx();
    setIdle();
    applyStimulus(1, 0, 5'd0, 2'd3, 0, 0, 0, 0);
    tick();
    setIdle();
    checks++; if (busy_o !== 64'd0 || out_cnt_o !== 3'd0) begin errors++; $display("[TB] FAIL x0_ignored: busy %h cnt %0d expected 0/0", busy_o, out_cnt_o); end
    applyStimulus(1, 0, 5'd7, 2'd1, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 5'd7, 2'd3, 1, 0, 5'd7, 2'd1);
    tick();
    setIdle();
    checks++; if (busy_o[7] !== 1'b1 || out_cnt_o !== 3'd1) begin errors++; $display("[TB] FAIL same_idx_set_wins: busy7 %b cnt %0d expected 1/1", busy_o[7], out_cnt_o); end
    applyStimulus(0, 0, 0, 0, 1, 0, 5'd7, 2'd1);
    tick();
    setIdle();
    checks++; if (busy_o[7] !== 1'b1) begin errors++; $display("[TB] FAIL same_idx_old_tag: busy7 %b expected 1", busy_o[7]); end
    applyStimulus(0, 0, 0, 0, 1, 0, 5'd7, 2'd3);
    tick();
    setIdle();
    checks++; if (busy_o[7] !== 1'b0 || out_cnt_o !== 3'd0) begin errors++; $display("[TB] FAIL same_idx_new_tag: busy7 %b cnt %0d expected 0/0", busy_o[7], out_cnt_o); end
  endtask

  task automatic test_async_reset();
    setIdle();
    applyStimulus(1, 0, 5'd1, 2'd1, 0, 0, 0, 0); tick();
    applyStimulus(1, 0, 5'd2, 2'd2, 0, 0, 0, 0); tick();
    applyStimulus(1, 0, 5'd3, 2'd3, 0, 0, 0, 0); tick();
    setIdle();
    rs1_i = 5'd1; rs_used_i = 3'b001;
    #1;
    checks++; if (out_cnt_o !== 3'd3 || stall_o !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset: cnt %0d stall %b expected 3/1", out_cnt_o, stall_o); end
    #1;
    rst_n_i = 0;
    #1;
    checks++; if (busy_o !== 64'd0 || out_cnt_o !== 3'd0 || stall_o !== 1'b0) begin errors++; $display("[TB] FAIL async_reset: busy %h cnt %0d stall %b expected 0/0/0", busy_o, out_cnt_o, stall_o); end
    modelReset();
    setIdle();
    @(negedge clk_i);
    rst_n_i = 1;
    tick();
  endtask

  task automatic test_random();
    int q[$];
    int k;
    for (int n = 0; n < 400; n++) begin
      setIdle();
      q.delete();
      for (int i = 0; i < 64; i++) if (mBusy[i]) q.push_back(i);
      if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
        k = q[$urandom_range(0, q.size() - 1)];
        wb_valid_i = 1; wb_fp_i = 1'(k / 32); wb_rd_i = 5'(k % 32);
        wb_unit_i = ($urandom_range(0, 4) == 0) ? UNIT_W'($urandom) : UNIT_W'(mTag[k]);
      end else if ($urandom_range(0, 3) == 0) begin
        wb_valid_i = 1; wb_fp_i = 1'($urandom); wb_rd_i = 5'($urandom_range(0, 3)); wb_unit_i = UNIT_W'($urandom);
      end
      rs1_i = 5'($urandom_range(0, 3)); rs1_fp_i = 1'($urandom);
      rs2_i = 5'($urandom_range(0, 3)); rs2_fp_i = 1'($urandom);
      rs3_i = 5'($urandom_range(0, 3)); rs3_fp_i = 1'($urandom);
      rs_used_i = 3'($urandom);
      rd_i = 5'($urandom_range(0, 3)); rd_fp_i = 1'($urandom);
      rd_used_i = ($urandom_range(0, 3) != 0);
      issue_rd_i = rd_i; issue_fp_i = rd_fp_i; issue_unit_i = UNIT_W'($urandom);
      issue_valid_i = rd_used_i && !mStall() && ($urandom_range(0, 1) == 1);
      #1;
      checks++; if (stall_o !== mStall()) begin errors++; $display("[TB] FAIL rand_stall cycle %0d: got %b expected %b", n, stall_o, mStall()); end
      tick();
      checks++; if (busy_o !== mBusyVec()) begin errors++; $display("[TB] FAIL rand_busy cycle %0d: got %h expected %h", n, busy_o, mBusyVec()); end
      checks++; if (out_cnt_o !== CNT_W'(mCnt)) begin errors++; $display("[TB] FAIL rand_cnt cycle %0d: got %0d expected %0d", n, out_cnt_o, mCnt); end
    end
    setIdle();
  endtask

  initial begin
    test_reset();
    test_raw_bypass();
    test_tag_mismatch();
    test_full();
    test_x0_same_idx();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
